// File: rtl/cpu_pkg.sv
// Shared CPU core types: opcode and phase encodings, the sequencer control
// vector, and the ALU-opcode membership test used by decode and datapath.
package cpu_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int PHASE_WIDTH  = 3;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [PHASE_WIDTH-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Raw decode of one phase; strobes are qualified by the sequencer top.
    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic data_e;
    } ctrl_t;

    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Pure combinational phase/opcode decode into the raw control vector. No
// gating here: run, halt, stall and restart qualification live in the top.
module seq_decode
    import cpu_pkg::*;
(
    input  phase_t  phase,
    input  opcode_t opcode,
    input  logic    zero,
    output ctrl_t   ctrl
);

    logic alu;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        ctrl = '0;
        alu  = is_aluop(opcode);
        case (phase)
            INST_ADDR: begin
                ctrl.sel = 1'b1;
            end
            INST_FETCH: begin
                ctrl.sel = 1'b1;
                ctrl.rd  = 1'b1;
            end
            INST_LOAD: begin
                ctrl.sel   = 1'b1;
                ctrl.rd    = 1'b1;
                ctrl.ld_ir = 1'b1;
            end
            IDLE: begin
                ctrl.sel = 1'b1;
                ctrl.rd  = 1'b1;
            end
            OP_ADDR: begin
                ctrl.inc_pc = 1'b1;
            end
            OP_FETCH: begin
                ctrl.rd = alu;
            end
            ALU_OP: begin
                // Skip-if-zero is a second PC increment; a jump only loads.
                ctrl.rd     = alu;
                ctrl.inc_pc = (opcode == SKZ) && zero;
                ctrl.ld_pc  = (opcode == JMP);
                ctrl.data_e = (opcode == STO);
            end
            STORE: begin
                ctrl.rd     = alu;
                ctrl.ld_ac  = alu;
                ctrl.ld_pc  = (opcode == JMP);
                ctrl.wr     = (opcode == STO);
                ctrl.data_e = (opcode == STO);
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer: owns the phase register and halt latch,
// applies memory wait-states, the run gate and restart to the raw decode.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_WIDTH,
    parameter int PHASE_W  = PHASE_WIDTH
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                run,
    input  logic                restart,
    input  logic                mem_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic [PHASE_W-1:0]  phase,
    output logic                sel,
    output logic                rd,
    output logic                wr,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                data_e,
    output logic                halt,
    output logic                instr_done
);

    phase_t  phase_q, phase_d;
    logic    halt_q, halt_d;
    opcode_t op;
    ctrl_t   dec;
    logic    stall;
    logic    strobe_en;
    logic    advance;

    assign op = opcode_t'(opcode);

    seq_decode u_decode (
        .phase  (phase_q),
        .opcode (op),
        .zero   (zero),
        .ctrl   (dec)
    );

    // Wait-states only apply to phases with a memory access that must complete.
    assign stall = ((phase_q == INST_FETCH) ||
                    ((phase_q == OP_FETCH) && dec.rd) ||
                    ((phase_q == STORE) && dec.wr)) && !mem_ready;

    assign strobe_en = run && !halt_q && !restart;
    assign advance   = strobe_en && !stall;

    always_comb begin
        phase_d = phase_q;
        halt_d  = halt_q;
        if (restart) begin
            phase_d = INST_ADDR;
            halt_d  = 1'b0;
        end else if (advance) begin
            phase_d = phase_t'(phase_q + 3'd1);
            if ((phase_q == OP_ADDR) && (op == HLT)) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_) begin
            phase_q <= INST_ADDR;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            halt_q  <= halt_d;
        end
    end

    assign phase  = phase_q;
    assign sel    = dec.sel;
    assign rd     = dec.rd;
    assign data_e = dec.data_e;
    assign halt   = halt_q;

    // wr stays up through wait-states so memory sees the request until mem_ready.
    assign wr     = dec.wr && strobe_en;
    assign ld_ir  = dec.ld_ir  && advance;
    assign inc_pc = dec.inc_pc && advance;
    assign ld_pc  = dec.ld_pc  && advance;
    assign ld_ac  = dec.ld_ac  && advance;

    assign instr_done = (phase_q == STORE) && advance;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: phase sweeps per opcode,
// wait-states, run gate, halt/restart and asynchronous reset.
module tb_cpu_sequencer;

    logic       clk;
    logic       rst_;
    logic       run;
    logic       restart;
    logic       mem_ready;
    logic [2:0] opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e;
    logic       halt;
    logic       instr_done;
    logic [7:0] ctrl_obs;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // ctrl_obs bits: sel rd wr ld_ir inc_pc ld_pc ld_ac data_e
    assign ctrl_obs = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e};

    cpu_sequencer dut (
        .clk        (clk),
        .rst_       (rst_),
        .run        (run),
        .restart    (restart),
        .mem_ready  (mem_ready),
        .opcode     (opcode),
        .zero       (zero),
        .phase      (phase),
        .sel        (sel),
        .rd         (rd),
        .wr         (wr),
        .ld_ir      (ld_ir),
        .inc_pc     (inc_pc),
        .ld_pc      (ld_pc),
        .ld_ac      (ld_ac),
        .data_e     (data_e),
        .halt       (halt),
        .instr_done (instr_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0; run = 1'b0; restart = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    // One full instruction; tbl holds expected ctrl_obs for phases 0..7, phase 0 in the top byte.
    task automatic sweep(input string name, input logic [2:0] op, input logic z,
                         input logic [63:0] tbl, input int exp_inc);
        int incs = 0;
        logic [7:0] exp_ctrl;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            opcode = op; zero = z; run = 1'b1; mem_ready = 1'b1; restart = 1'b0;
            #1;
            exp_ctrl = tbl[(7-p)*8 +: 8];
            n_checks++;
            if (phase !== 3'(p)) begin
                n_fail++;
                $display("FAIL %s phase step %0d: got %0d want %0d", name, p, phase, p);
            end
            n_checks++;
            if (ctrl_obs !== exp_ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl phase %0d: got %b want %b", name, p, ctrl_obs, exp_ctrl);
            end
            n_checks++;
            if (instr_done !== (p == 7)) begin
                n_fail++;
                $display("FAIL %s instr_done phase %0d: got %b want %b", name, p, instr_done, (p == 7));
            end
            n_checks++;
            if ((inc_pc & ld_pc) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s inc_pc&ld_pc phase %0d: got 1 want 0", name, p);
            end
            if (inc_pc === 1'b1) incs++;
        end
        n_checks++;
        if (incs != exp_inc) begin
            n_fail++;
            $display("FAIL %s pc increments: got %0d want %0d", name, incs, exp_inc);
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0; run = 1'b1; restart = 1'b0; mem_ready = 1'b1; opcode = OP_ADD; zero = 1'b0;
        #1;
        n_checks++;
        if (phase !== 3'd0) begin
            n_fail++; $display("FAIL reset phase: got %0d want 0", phase);
        end
        n_checks++;
        if ({ctrl_obs, halt, instr_done} !== 10'b1000_0000_00) begin
            n_fail++; $display("FAIL reset outputs: got %b want 1000000000", {ctrl_obs, halt, instr_done});
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (phase !== 3'd0) begin
            n_fail++; $display("FAIL reset hold phase: got %0d want 0", phase);
        end
        rst_ = 1'b1; run = 1'b0;
    endtask

    task automatic test_add();
        sweep("add", OP_ADD, 1'b0, 64'h80C0D0C0_08404042, 1);
        sweep("lda", OP_LDA, 1'b1, 64'h80C0D0C0_08404042, 1);
    endtask

    task automatic test_jmp();
        sweep("jmp", OP_JMP, 1'b0, 64'h80C0D0C0_08000404, 1);
    endtask

    task automatic test_skz();
        sweep("skz_z1", OP_SKZ, 1'b1, 64'h80C0D0C0_08000800, 2);
        sweep("skz_z0", OP_SKZ, 1'b0, 64'h80C0D0C0_08000000, 1);
    endtask

    task automatic test_run_gate();
        tick_n(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run = 1'b0;
            #1;
            n_checks++;
            if ({phase, ctrl_obs} !== {3'd2, 8'hC0}) begin
                n_fail++; $display("FAIL run_gate frozen: got %0d/%b want 2/11000000", phase, ctrl_obs);
            end
        end
        @(negedge clk);
        run = 1'b1;
        #1;
        n_checks++;
        if ({phase, ctrl_obs} !== {3'd2, 8'hD0}) begin
            n_fail++; $display("FAIL run_gate resume: got %0d/%b want 2/11010000", phase, ctrl_obs);
        end
        tick_n(5);
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        opcode = OP_STO; zero = 1'b0; run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            n_checks++;
            if ({phase, ctrl_obs} !== {3'd1, 8'hC0}) begin
                n_fail++; $display("FAIL fetch_stall: got %0d/%b want 1/11000000", phase, ctrl_obs);
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        tick_n(5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            n_checks++;
            if ({phase, ctrl_obs, instr_done} !== {3'd7, 8'h21, 1'b0}) begin
                n_fail++; $display("FAIL store_stall: got %0d/%b/%b want 7/00100001/0", phase, ctrl_obs, instr_done);
            end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if ({phase, ctrl_obs, instr_done} !== {3'd7, 8'h21, 1'b1}) begin
            n_fail++; $display("FAIL store_ready: got %0d/%b/%b want 7/00100001/1", phase, ctrl_obs, instr_done);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (phase !== 3'd0) begin
            n_fail++; $display("FAIL store_wrap phase: got %0d want 0", phase);
        end
    endtask

    task automatic test_halt();
        do_reset();
        @(negedge clk);
        opcode = OP_HLT; zero = 1'b0; run = 1'b1; mem_ready = 1'b1;
        tick_n(3);
        @(negedge clk);
        #1;
        n_checks++;
        if ({phase, ctrl_obs, halt} !== {3'd4, 8'h08, 1'b0}) begin
            n_fail++; $display("FAIL hlt op_addr: got %0d/%b/%b want 4/00001000/0", phase, ctrl_obs, halt);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({phase, ctrl_obs, halt} !== {3'd5, 8'h00, 1'b1}) begin
                n_fail++; $display("FAIL hlt frozen cycle %0d: got %0d/%b/%b want 5/00000000/1", i, phase, ctrl_obs, halt);
            end
        end
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        #1;
        n_checks++;
        if ({phase, ctrl_obs, halt} !== {3'd0, 8'h80, 1'b0}) begin
            n_fail++; $display("FAIL hlt restart: got %0d/%b/%b want 0/10000000/0", phase, ctrl_obs, halt);
        end
    endtask

    task automatic test_restart();
        tick_n(3);
        @(negedge clk);
        restart = 1'b1;
        #1;
        n_checks++;
        if ({phase, ctrl_obs} !== {3'd4, 8'h00}) begin
            n_fail++; $display("FAIL restart abort: got %0d/%b want 4/00000000", phase, ctrl_obs);
        end
        @(negedge clk);
        restart = 1'b0; run = 1'b0;
        #1;
        n_checks++;
        if ({phase, halt} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL restart beats halt: got %0d/%b want 0/0", phase, halt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        opcode = OP_STO; zero = 1'b0; run = 1'b1; mem_ready = 1'b1;
        tick_n(5);
        @(negedge clk);
        #1;
        n_checks++;
        if ({phase, ctrl_obs} !== {3'd6, 8'h01}) begin
            n_fail++; $display("FAIL sto alu_op: got %0d/%b want 6/00000001", phase, ctrl_obs);
        end
        #2;
        rst_ = 1'b0;
        #1;
        n_checks++;
        if ({phase, ctrl_obs, halt, instr_done} !== {3'd0, 8'h80, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL async reset: got %0d/%b/%b/%b want 0/10000000/0/0", phase, ctrl_obs, halt, instr_done);
        end
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_jmp();
        test_skz();
        test_run_gate();
        test_stall();
        test_halt();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
